// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall controller bundle: decode and stage sideband in, stall/redirect out.
// The controller takes the slave view; the pipeline (or a bench) drives through master.
interface pipeline_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic [4:0]            rs1_raddr_i;
    logic [4:0]            rs2_raddr_i;
    logic                  rs1_re_i;
    logic                  rs2_re_i;
    logic                  ex_is_load_i;
    logic [4:0]            ex_rd_i;
    logic                  ex_busy_i;
    logic                  mem_req_i;
    logic                  mem_ready_i;
    logic                  jump_req_i;
    logic [ADDR_WIDTH-1:0] jump_addr_i;
    logic [5:0]            stall_o;
    logic                  flush_jump_o;
    logic                  jump_o;
    logic [ADDR_WIDTH-1:0] jump_addr_o;
    logic                  mem_timeout_o;
    logic [CNT_WIDTH-1:0]  stall_cnt_o;

    modport slave (
        input  rs1_raddr_i, rs2_raddr_i, rs1_re_i, rs2_re_i,
        input  ex_is_load_i, ex_rd_i, ex_busy_i,
        input  mem_req_i, mem_ready_i, jump_req_i, jump_addr_i,
        output stall_o, flush_jump_o, jump_o, jump_addr_o,
        output mem_timeout_o, stall_cnt_o
    );

    modport master (
        output rs1_raddr_i, rs2_raddr_i, rs1_re_i, rs2_re_i,
        output ex_is_load_i, ex_rd_i, ex_busy_i,
        output mem_req_i, mem_ready_i, jump_req_i, jump_addr_i,
        input  stall_o, flush_jump_o, jump_o, jump_addr_o,
        input  mem_timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the 5-stage RV32 pipeline: stall vector, jump flush,
// deferred redirect under stall, MEM wait watchdog and stall-cycle counter.
module pipeline_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    pipeline_ctrl_if.slave  bus
);
    localparam int WD_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_EXE_WAIT = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  jump_pend_q, jump_pend_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

    logic                  wd_expire;
    logic                  mem_wait;
    logic                  exe_wait;
    logic                  load_use;
    logic                  take_jump;
    logic [5:0]            stall;
    logic                  flush;
    logic                  jump;
    logic [ADDR_WIDTH-1:0] jump_addr;

    assign wd_expire = (wd_cnt_q == WD_W'(MEM_TIMEOUT));
    assign mem_wait  = bus.mem_req_i & ~bus.mem_ready_i & ~wd_expire;
    assign exe_wait  = bus.ex_busy_i;
    assign load_use  = bus.ex_is_load_i & (bus.ex_rd_i != 5'd0) &
                       ((bus.rs1_re_i & (bus.rs1_raddr_i == bus.ex_rd_i)) |
                        (bus.rs2_re_i & (bus.rs2_raddr_i == bus.ex_rd_i)));
    // A redirect (fresh or held) goes out on the first cycle with no wait active.
    assign take_jump = ~(mem_wait | exe_wait) & (bus.jump_req_i | jump_pend_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mem_wait)      state_d = ST_MEM_WAIT;
                else if (exe_wait) state_d = ST_EXE_WAIT;
            end
            ST_MEM_WAIT: begin
                if (!mem_wait)     state_d = exe_wait ? ST_EXE_WAIT : ST_RUN;
            end
            ST_EXE_WAIT: begin
                if (mem_wait)      state_d = ST_MEM_WAIT;
                else if (!exe_wait) state_d = ST_RUN;
            end
            default:               state_d = ST_RUN;
        endcase
    end

    // Flush beats a simultaneous load-use stall: the dependent instruction is squashed anyway.
    always_comb begin
        stall     = 6'b000000;
        flush     = 1'b0;
        jump      = 1'b0;
        jump_addr = '0;
        if (rst_n_i) begin
            if (take_jump) begin
                flush     = 1'b1;
                jump      = 1'b1;
                jump_addr = bus.jump_req_i ? bus.jump_addr_i : pend_addr_q;
            end
            if (mem_wait)                    stall = 6'b011111;
            else if (exe_wait)               stall = 6'b001111;
            else if (load_use && !take_jump) stall = 6'b000111;
        end
    end

    always_comb begin
        jump_pend_d = jump_pend_q;
        pend_addr_d = pend_addr_q;
        if (bus.jump_req_i && (mem_wait || exe_wait)) begin
            jump_pend_d = 1'b1;
            pend_addr_d = bus.jump_addr_i;
        end else if (take_jump) begin
            jump_pend_d = 1'b0;
        end

        wd_cnt_d  = mem_wait ? wd_cnt_q + 1'b1 : '0;
        timeout_d = timeout_q | wd_expire;

        stall_cnt_d = stall_cnt_q;
        if ((stall != 6'b000000) && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            jump_pend_q <= 1'b0;
            pend_addr_q <= '0;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            jump_pend_q <= jump_pend_d;
            pend_addr_q <= pend_addr_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_o       = stall;
    assign bus.flush_jump_o  = flush;
    assign bus.jump_o        = jump;
    assign bus.jump_addr_o   = jump_addr;
    // The expiring cycle already reports the timeout; the register keeps it afterwards.
    assign bus.mem_timeout_o = timeout_q | wd_expire;
    assign bus.stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_ctrl;
    localparam int AW = 32;
    localparam int CW = 32;

    logic clk;
    logic rst_n;

    pipeline_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    pipeline_ctrl #(.ADDR_WIDTH(AW), .MEM_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]    stall;
        logic          flush;
        logic          jump;
        logic [AW-1:0] addr;
        logic          tmo;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests  = 0;
    int    fails  = 0;
    logic          exp_to  = 1'b0;
    logic [CW-1:0] exp_cnt = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            chk({n, ".stall"}, 32'(bus.stall_o), 32'(e.stall));
            chk({n, ".flush"}, 32'(bus.flush_jump_o), 32'(e.flush));
            chk({n, ".jump"},  32'(bus.jump_o), 32'(e.jump));
            if (e.jump) chk({n, ".jaddr"}, bus.jump_addr_o, e.addr);
            chk({n, ".tmo"},   32'(bus.mem_timeout_o), 32'(e.tmo));
            chk({n, ".cnt"},   bus.stall_cnt_o, e.cnt);
        end
    end

    // Inputs are already set for this cycle; queue expectations, then advance one clock.
    task automatic step(input logic [5:0] s, input logic f, input logic j,
                        input logic [AW-1:0] a, input string nm);
        exp_t e;
        e.stall = s; e.flush = f; e.jump = j; e.addr = a;
        e.tmo = exp_to; e.cnt = exp_cnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (s != 6'd0 && exp_cnt != {CW{1'b1}}) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rs1_raddr_i = 5'd0; bus.rs2_raddr_i = 5'd0;
        bus.rs1_re_i = 1'b0; bus.rs2_re_i = 1'b0;
        bus.ex_is_load_i = 1'b0; bus.ex_rd_i = 5'd0; bus.ex_busy_i = 1'b0;
        bus.mem_req_i = 1'b0; bus.mem_ready_i = 1'b0;
        bus.jump_req_i = 1'b0; bus.jump_addr_i = '0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        bus.ex_is_load_i = 1'b1; bus.ex_rd_i = rd;
        bus.rs1_re_i = 1'b1; bus.rs1_raddr_i = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        step(6'b000000, 0, 0, 0, "reset");
        rst_n = 1'b1;

        // load-use via rs1, then rd=0, then via rs2, then non-load
        set_load_use(5'd5);                      step(6'b000111, 0, 0, 0, "lu_rs1");
        idle_inputs();                           step(6'b000000, 0, 0, 0, "lu_clear");
        set_load_use(5'd0);                      step(6'b000000, 0, 0, 0, "lu_x0");
        idle_inputs();
        bus.ex_is_load_i = 1'b1; bus.ex_rd_i = 5'd7;
        bus.rs2_re_i = 1'b1; bus.rs2_raddr_i = 5'd7; step(6'b000111, 0, 0, 0, "lu_rs2");
        bus.ex_is_load_i = 1'b0;                 step(6'b000000, 0, 0, 0, "lu_noload");
        idle_inputs();

        // exe busy 4 cycles
        bus.ex_busy_i = 1'b1;
        for (int i = 0; i < 4; i++) step(6'b001111, 0, 0, 0, "exe_busy");
        bus.ex_busy_i = 1'b0;                    step(6'b000000, 0, 0, 0, "exe_done");

        // mem wait overlapping exe busy
        bus.ex_busy_i = 1'b1; bus.mem_req_i = 1'b1;
        for (int i = 0; i < 3; i++) step(6'b011111, 0, 0, 0, "mem_exe");
        bus.mem_req_i = 1'b0;
        for (int i = 0; i < 2; i++) step(6'b001111, 0, 0, 0, "exe_after_mem");
        bus.ex_busy_i = 1'b0;                    step(6'b000000, 0, 0, 0, "mem_exe_done");

        // deferred jump during 2-cycle mem wait
        bus.mem_req_i = 1'b1; bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h100;
        step(6'b011111, 0, 0, 0, "dj_wait1");
        bus.jump_req_i = 1'b0; bus.jump_addr_i = 32'hDEAD;
        step(6'b011111, 0, 0, 0, "dj_wait2");
        bus.mem_req_i = 1'b0;                    step(6'b000000, 1, 1, 32'h100, "dj_release");
        step(6'b000000, 0, 0, 0, "dj_cleared");

        // latest pending jump wins
        bus.ex_busy_i = 1'b1; bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h300;
        step(6'b001111, 0, 0, 0, "lw_1");
        bus.jump_addr_i = 32'h304;               step(6'b001111, 0, 0, 0, "lw_2");
        bus.ex_busy_i = 1'b0; bus.jump_req_i = 1'b0;
        step(6'b000000, 1, 1, 32'h304, "lw_release");
        step(6'b000000, 0, 0, 0, "lw_cleared");

        // fresh jump on the release cycle beats the held one
        bus.ex_busy_i = 1'b1; bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h400;
        step(6'b001111, 0, 0, 0, "rj_hold");
        bus.ex_busy_i = 1'b0; bus.jump_addr_i = 32'h500;
        step(6'b000000, 1, 1, 32'h500, "rj_release");
        bus.jump_req_i = 1'b0;                   step(6'b000000, 0, 0, 0, "rj_cleared");

        // immediate jump, then jump against load-use
        bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h600;
        step(6'b000000, 1, 1, 32'h600, "jump_now");
        set_load_use(5'd9); bus.jump_addr_i = 32'h200;
        step(6'b000000, 1, 1, 32'h200, "jump_vs_lu");
        idle_inputs();                           step(6'b000000, 0, 0, 0, "jlu_clear");

        // watchdog: 4 stalled cycles, released on the 5th, sticky flag
        bus.mem_req_i = 1'b1;
        for (int i = 0; i < 4; i++) step(6'b011111, 0, 0, 0, "wd_wait");
        exp_to = 1'b1;                           step(6'b000000, 0, 0, 0, "wd_expire");
        step(6'b011111, 0, 0, 0, "wd_rewait");
        bus.mem_ready_i = 1'b1;                  step(6'b000000, 0, 0, 0, "wd_ready");
        idle_inputs();                           step(6'b000000, 0, 0, 0, "wd_sticky");

        // reset mid-wait with a pending jump
        bus.mem_req_i = 1'b1; bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h700;
        step(6'b011111, 0, 0, 0, "rst_pre");
        bus.jump_req_i = 1'b0;
        rst_n = 1'b0; exp_to = 1'b0; exp_cnt = '0;
        step(6'b000000, 0, 0, 0, "rst_mid");
        rst_n = 1'b1; bus.mem_req_i = 1'b0;
        step(6'b000000, 0, 0, 0, "rst_nopend");

        @(negedge clk); #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
